// File: rtl/pattern_eval_sequencer_if.sv
// rtl/pattern_eval_sequencer_if.sv - control, stimulus and response bundle for the pattern sequencer
interface pattern_eval_sequencer_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [CNT_W-1:0] num_pat;
  logic [IN_W-1:0]  seed;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] resp_a;
  logic [OUT_W-1:0] resp_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             fail_valid;
  logic [IN_W-1:0]  fail_pat;
  logic [15:0]      sig;

  modport master (
    output start, abort, mode, num_pat, seed, resp_a, resp_b,
    input  stim, busy, done, mismatch_cnt, fail_valid, fail_pat, sig
  );

  modport slave (
    input  start, abort, mode, num_pat, seed, resp_a, resp_b,
    output stim, busy, done, mismatch_cnt, fail_valid, fail_pat, sig
  );
endinterface

// File: rtl/pattern_eval_sequencer.sv
// rtl/pattern_eval_sequencer.sv - drives exhaustive or LFSR stimulus into two netlists and compares responses
module pattern_eval_sequencer #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  pattern_eval_sequencer_if.slave bus
);
  // Fibonacci tap masks for common widths; other widths fall back to the two top bits.
  localparam logic [31:0] TAPS32 = (IN_W == 14) ? 32'h0000_3802 :
                                   (IN_W == 16) ? 32'h0000_D008 :
                                   (IN_W == 8)  ? 32'h0000_00B8 :
                                   (32'h3 << (IN_W - 2));
  localparam logic [IN_W-1:0] TAP_MASK = TAPS32[IN_W-1:0];

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CAPTURE, S_FIN} state_t;

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_left;
  logic [IN_W-1:0]  r_cur;
  logic [IN_W-1:0]  r_stim;
  logic [3:0]       r_wait;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_mm_cnt;
  logic             r_fail_valid;
  logic [IN_W-1:0]  r_fail_pat;
  logic [15:0]      r_sig;

  logic [IN_W-1:0]  w_lfsr_next;
  logic [IN_W-1:0]  w_seed_eff;
  logic [15:0]      w_resp_ext;
  logic [15:0]      w_sig_next;
  logic             w_mismatch;
  logic             w_last;

  generate
    if (OUT_W >= 16) begin : g_resp_trunc
      assign w_resp_ext = bus.resp_b[15:0];
    end else begin : g_resp_ext
      assign w_resp_ext = {{(16-OUT_W){1'b0}}, bus.resp_b};
    end
  endgenerate

  assign w_lfsr_next = {r_cur[IN_W-2:0], ^(r_cur & TAP_MASK)};
  assign w_seed_eff  = (bus.seed == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : bus.seed;
  assign w_sig_next  = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ w_resp_ext;
  assign w_mismatch  = (bus.resp_a != bus.resp_b);
  // Exhaustive runs end on the all-ones pattern; LFSR runs end when the count runs out.
  assign w_last      = r_mode ? (r_left == {{(CNT_W-1){1'b0}}, 1'b1}) : (r_stim == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_left       <= '0;
      r_cur        <= '0;
      r_stim       <= '0;
      r_wait       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mm_cnt     <= '0;
      r_fail_valid <= 1'b0;
      r_fail_pat   <= '0;
      r_sig        <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_mm_cnt     <= '0;
              r_fail_valid <= 1'b0;
              r_sig        <= '0;
              r_mode       <= bus.mode;
              r_left       <= bus.num_pat;
              r_cur        <= bus.mode ? w_seed_eff : '0;
              r_busy       <= 1'b1;
              r_state      <= (bus.mode && bus.num_pat == '0) ? S_FIN : S_APPLY;
            end
          end
          S_APPLY: begin
            r_stim  <= r_cur;
            r_cur   <= r_mode ? w_lfsr_next : r_cur + 1'b1;
            r_wait  <= 4'(SETTLE - 1);
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (r_wait == 4'd0) r_state <= S_CAPTURE;
            else                r_wait  <= r_wait - 4'd1;
          end
          S_CAPTURE: begin
            if (w_mismatch) begin
              if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + 1'b1;
              if (!r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_pat   <= r_stim;
              end
            end
            r_sig   <= w_sig_next;
            r_left  <= r_left - 1'b1;
            r_state <= w_last ? S_FIN : S_APPLY;
          end
          S_FIN: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.stim         = r_stim;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.mismatch_cnt = r_mm_cnt;
  assign bus.fail_valid   = r_fail_valid;
  assign bus.fail_pat     = r_fail_pat;
  assign bus.sig          = r_sig;
endmodule
